// File: rtl/temp_conv_seq.sv
// -----------------------------------------------------------------------------
// temp_conv_seq
//
// Sequential Celsius converter with three output modes: C->C, C->F and C->K.
// The operand is captured with ld and a conversion is started with st. The
// C->F path uses an iterative shift-add multiplier that consumes one bit of
// F_MUL per cycle, LSB first. All other modes finish in a single CALC cycle.
// Every result is computed at full width and then saturated to OUT_W bits.
// An over-temperature alarm with hysteresis is updated only when a valid-mode
// result is registered.
//
// Ports
//   clk       in   1      system clock, rising edge
//   clr       in   1      asynchronous active-low reset
//   X         in   W      Celsius operand
//   ld        in   1      load X into the operand register (IDLE/DONE only)
//   sel       in   2      mode: 0 = C, 1 = F, 2 = K, 3 = invalid
//   st        in   1      start conversion (IDLE/DONE only)
//   result    out  OUT_W  last converted value
//   valid     out  1      one-cycle pulse when result updates
//   busy      out  1      conversion in progress
//   sat       out  1      last result was saturated
//   err       out  1      last conversion was started with sel = 3
//   alarm     out  1      hysteresis over-temperature flag
//   mode_led  out  3      one-hot latched mode (C, F, K), 0 for invalid
// -----------------------------------------------------------------------------
module temp_conv_seq #(
  parameter int W       = 4,
  parameter int OUT_W   = 4,
  parameter int F_MUL   = 5,
  parameter int MUL_W   = 3,
  parameter int F_SHIFT = 3,
  parameter int F_OFF   = 2,
  parameter int K_OFF   = 3,
  parameter int HI_THR  = 12,
  parameter int LO_THR  = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [W-1:0]     X,
  input  logic             ld,
  input  logic [1:0]       sel,
  input  logic             st,
  output logic [OUT_W-1:0] result,
  output logic             valid,
  output logic             busy,
  output logic             sat,
  output logic             err,
  output logic             alarm,
  output logic [2:0]       mode_led
);

  // Full-width arithmetic: X*F_MUL needs W+MUL_W bits, plus one for the offset.
  localparam int FULL_W = W + MUL_W + 1;
  localparam int CNT_W  = (MUL_W > 1) ? $clog2(MUL_W) : 1;

  localparam logic [MUL_W-1:0]  F_MUL_V  = MUL_W'(F_MUL);
  localparam logic [FULL_W-1:0] SAT_MAX  = FULL_W'((2 ** OUT_W) - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MUL_W - 1);
  localparam logic [OUT_W-1:0]  HI_V     = OUT_W'(HI_THR);
  localparam logic [OUT_W-1:0]  LO_V     = OUT_W'(LO_THR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_C   = 2'd0,
    MODE_F   = 2'd1,
    MODE_K   = 2'd2,
    MODE_BAD = 2'd3
  } mode_t;

  state_t            state;
  mode_t             mode;
  logic [W-1:0]      operand;
  logic [FULL_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  // Combinational datapath
  logic [FULL_W-1:0] op_ext;
  logic [MUL_W-1:0]  mul_bits;
  logic [FULL_W-1:0] acc_next;
  logic [FULL_W-1:0] conv_full;
  logic              conv_sat;
  logic [OUT_W-1:0]  conv_res;
  logic              last_calc;
  logic              can_accept;

  function automatic logic [2:0] led_of(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // ld and st are only honoured outside CALC, i.e. whenever busy is low.
  assign can_accept = (state != S_CALC);

  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path
    // leaves it unassigned; a missing default here would infer a latch.
    op_ext    = FULL_W'(operand);
    mul_bits  = F_MUL_V >> cnt;
    acc_next  = acc;
    conv_full = '0;

    // Shift-add step: bit cnt of the multiplier selects operand<<cnt.
    if (mul_bits[0]) begin
      acc_next = acc + (op_ext << cnt);
    end

    // F needs all MUL_W multiplier steps; the other modes finish at once.
    last_calc = (mode != MODE_F) || (cnt == LAST_CNT);

    case (mode)
      MODE_C:  conv_full = op_ext;
      MODE_F:  conv_full = (acc_next >> F_SHIFT) + FULL_W'(F_OFF);
      MODE_K:  conv_full = op_ext + FULL_W'(K_OFF);
      default: conv_full = '0;
    endcase

    conv_sat = (conv_full > SAT_MAX);
    conv_res = conv_sat ? OUT_W'(SAT_MAX) : OUT_W'(conv_full);
  end

  // Single sequential block: control FSM plus every registered output.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      mode     <= MODE_C;
      operand  <= '0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      sat      <= 1'b0;
      err      <= 1'b0;
      alarm    <= 1'b0;
      mode_led <= 3'b000;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value regardless of statement order.
      valid <= 1'b0;

      // Loading on the accept edge means the following CALC cycles already
      // see the new X, which makes a same-edge ld+st use the current X.
      if (ld && can_accept) begin
        operand <= X;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (st) begin
            mode     <= mode_t'(sel);
            mode_led <= led_of(sel);
            busy     <= 1'b1;
            acc      <= '0;
            cnt      <= '0;
            state    <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end

        S_CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last_calc) begin
            result <= conv_res;
            sat    <= conv_sat;
            err    <= (mode == MODE_BAD);
            valid  <= 1'b1;
            busy   <= 1'b0;
            state  <= S_DONE;
            // Hysteresis: set above HI, clear below LO, otherwise hold.
            // An invalid-mode result carries no temperature, so it is skipped.
            if (mode != MODE_BAD) begin
              if (conv_res > HI_V) begin
                alarm <= 1'b1;
              end else if (conv_res < LO_V) begin
                alarm <= 1'b0;
              end
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
